// File: rtl/fwd_hazard_ctrl_pkg.sv
// ============================================================================
// Module  : fwd_hazard_ctrl_pkg
// Brief   : Shared constants and types for the execute-stage forwarding and
//           hazard controller: select encoding, address width, slot record.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package fwd_hazard_ctrl_pkg;

  localparam int FORW_SEL_LEN      = 2;
  localparam int REG_FILE_ADDR_LEN = 5;

  // Forwarding mux select encoding; code 3 is never driven.
  localparam logic [FORW_SEL_LEN-1:0] SEL_REG = 2'd0;
  localparam logic [FORW_SEL_LEN-1:0] SEL_MEM = 2'd1;
  localparam logic [FORW_SEL_LEN-1:0] SEL_WB  = 2'd2;

  // Shadow register-usage record for one pipeline stage.
  typedef struct packed {
    logic                         valid;
    logic [REG_FILE_ADDR_LEN-1:0] dest;
    logic                         wb_en;
    logic                         mem_read;
  } slot_t;

  localparam int    SLOT_W     = $bits(slot_t);
  localparam slot_t SLOT_EMPTY = '0;

  // A slot produces register r if it is live, writes back, and r is not x0.
  function automatic logic slot_writes(input slot_t s,
                                       input logic [REG_FILE_ADDR_LEN-1:0] r);
    return s.valid & s.wb_en & (s.dest == r) & (r != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_hazard_ctrl_fwd_match.sv
// ============================================================================
// Module  : fwd_match
// Brief   : Compares one ID source register against the EX and MEM slots and
//           returns the forwarding select (youngest producer wins), a RAW flag
//           and a flag for a RAW against a load sitting in EX.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_match
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic [REG_FILE_ADDR_LEN-1:0] i_src,
  input  logic [SLOT_W-1:0]            i_ex_slot,
  input  logic [SLOT_W-1:0]            i_mem_slot,
  output logic [FORW_SEL_LEN-1:0]      o_sel,
  output logic                         o_raw,
  output logic                         o_load_hit
);

  slot_t w_ex;
  slot_t w_mem;
  logic  w_ex_hit;
  logic  w_mem_hit;

  assign w_ex  = slot_t'(i_ex_slot);
  assign w_mem = slot_t'(i_mem_slot);

  assign w_ex_hit  = slot_writes(w_ex, i_src);
  assign w_mem_hit = slot_writes(w_mem, i_src);

  assign o_raw      = w_ex_hit | w_mem_hit;
  assign o_load_hit = w_ex_hit & w_ex.mem_read;

  // EX holds the younger producer, so it is checked before MEM.
  always_comb begin
    o_sel = SEL_REG;
    if (w_ex_hit) begin
      o_sel = SEL_MEM;
    end else if (w_mem_hit) begin
      o_sel = SEL_WB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
// ============================================================================
// Module  : fwd_hazard_ctrl
// Brief   : Execute-stage forwarding and hazard controller. Shadows register
//           usage of EX/MEM/WB, drives registered forwarding selects for
//           operand 1, operand 2 and store data, detects hazards that need an
//           ID stall with an EX bubble, and counts stall cycles (saturating).
//           Macro FWD_HAZARD_FORWARDING_EN: when defined, results are forwarded
//           and only load-use stalls; when undefined, selects stay SEL_REG and
//           any RAW against a writing EX or MEM slot stalls.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_freeze,
  input  logic                  i_flush,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_src1,
  input  logic [REG_ADDR_W-1:0] i_id_src2,
  input  logic                  i_id_src2_is_reg,
  input  logic                  i_id_is_store,
  input  logic [REG_ADDR_W-1:0] i_id_dest,
  input  logic                  i_id_wb_en,
  input  logic                  i_id_mem_read,
  output logic                  o_hazard_stall,
  output logic [SEL_W-1:0]      o_val1_sel,
  output logic [SEL_W-1:0]      o_val2_sel,
  output logic [SEL_W-1:0]      o_st_val_sel,
  output logic [CNT_W-1:0]      o_stall_cnt
);

  // WB slot is kept as part of the shadow pipeline image; nothing forwards
  // from beyond WB because the register file is write-first.
  slot_t r_ex;
  slot_t r_mem;
  slot_t r_wb;

  logic [SEL_W-1:0] r_val1_sel;
  logic [SEL_W-1:0] r_val2_sel;
  logic [SEL_W-1:0] r_st_val_sel;
  logic [CNT_W-1:0] r_stall_cnt;

  slot_t                   w_id_slot;
  logic [FORW_SEL_LEN-1:0] w_sel1, w_sel2, w_selst;
  logic                    w_raw1, w_raw2, w_rawst;
  logic                    w_ld1, w_ld2, w_ldst;
  logic                    w_dep;
  logic                    w_hazard;
  logic                    w_issue;
  logic [SEL_W-1:0]        w_nsel1, w_nsel2, w_nselst;

  assign w_id_slot = '{valid: 1'b1, dest: i_id_dest, wb_en: i_id_wb_en,
                       mem_read: i_id_mem_read};

  fwd_match u_match_src1 (
    .i_src      (i_id_src1),
    .i_ex_slot  (r_ex),
    .i_mem_slot (r_mem),
    .o_sel      (w_sel1),
    .o_raw      (w_raw1),
    .o_load_hit (w_ld1)
  );

  fwd_match u_match_src2 (
    .i_src      (i_id_src2),
    .i_ex_slot  (r_ex),
    .i_mem_slot (r_mem),
    .o_sel      (w_sel2),
    .o_raw      (w_raw2),
    .o_load_hit (w_ld2)
  );

  // Store data is read through the src2 port of the register file.
  fwd_match u_match_store (
    .i_src      (i_id_src2),
    .i_ex_slot  (r_ex),
    .i_mem_slot (r_mem),
    .o_sel      (w_selst),
    .o_raw      (w_rawst),
    .o_load_hit (w_ldst)
  );

`ifdef FWD_HAZARD_FORWARDING_EN
  // Only a load in EX cannot be forwarded in time.
  assign w_dep    = w_ld1 | (w_ld2 & i_id_src2_is_reg) | (w_ldst & i_id_is_store);
  assign w_nsel1  = w_sel1;
  assign w_nsel2  = i_id_src2_is_reg ? w_sel2 : SEL_REG;
  assign w_nselst = i_id_is_store ? w_selst : SEL_REG;
`else
  // No bypass paths: wait until the producer has reached WB.
  assign w_dep    = w_raw1 | (w_raw2 & i_id_src2_is_reg) | (w_rawst & i_id_is_store);
  assign w_nsel1  = SEL_REG;
  assign w_nsel2  = SEL_REG;
  assign w_nselst = SEL_REG;
`endif

  // A flushed ID instruction is dead, so it can never cause a stall.
  assign w_hazard = i_id_valid & ~i_flush & w_dep;
  assign w_issue  = i_id_valid & ~i_flush & ~w_hazard;

  // Advance the shadow pipeline and register the selects for the EX entrant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex         <= SLOT_EMPTY;
      r_mem        <= SLOT_EMPTY;
      r_wb         <= SLOT_EMPTY;
      r_val1_sel   <= SEL_REG;
      r_val2_sel   <= SEL_REG;
      r_st_val_sel <= SEL_REG;
    end else if (!i_freeze) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      if (w_issue) begin
        r_ex         <= w_id_slot;
        r_val1_sel   <= w_nsel1;
        r_val2_sel   <= w_nsel2;
        r_st_val_sel <= w_nselst;
      end else begin
        r_ex         <= SLOT_EMPTY;
        r_val1_sel   <= SEL_REG;
        r_val2_sel   <= SEL_REG;
        r_st_val_sel <= SEL_REG;
      end
    end
  end

  // Count stall cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (!i_freeze && w_hazard && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_hazard_stall = w_hazard;
  assign o_val1_sel     = r_val1_sel;
  assign o_val2_sel     = r_val2_sel;
  assign o_st_val_sel   = r_st_val_sel;
  assign o_stall_cnt    = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
// ============================================================================
// Module  : tb_fwd_hazard_ctrl
// Brief   : Self-checking bench for fwd_hazard_ctrl. Instruction table with
//           expected stall cycles and EX-cycle selects for both builds
//           (FWD_HAZARD_FORWARDING_EN defined / undefined), plus freeze,
//           reset-mid-stall and counter saturation sequences. A second
//           instance with a 3-bit counter exercises saturation.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fwd_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       i_freeze;
  logic       i_flush;
  logic       i_id_valid;
  logic [4:0] i_id_src1;
  logic [4:0] i_id_src2;
  logic       i_id_src2_is_reg;
  logic       i_id_is_store;
  logic [4:0] i_id_dest;
  logic       i_id_wb_en;
  logic       i_id_mem_read;

  logic        o_hazard_stall;
  logic [1:0]  o_val1_sel, o_val2_sel, o_st_val_sel;
  logic [15:0] o_stall_cnt;

  logic        b_hazard_stall;
  logic [1:0]  b_val1_sel, b_val2_sel, b_st_val_sel;
  logic [2:0]  b_stall_cnt;

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .SEL_W(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_freeze(i_freeze), .i_flush(i_flush),
    .i_id_valid(i_id_valid), .i_id_src1(i_id_src1), .i_id_src2(i_id_src2),
    .i_id_src2_is_reg(i_id_src2_is_reg), .i_id_is_store(i_id_is_store),
    .i_id_dest(i_id_dest), .i_id_wb_en(i_id_wb_en), .i_id_mem_read(i_id_mem_read),
    .o_hazard_stall(o_hazard_stall), .o_val1_sel(o_val1_sel), .o_val2_sel(o_val2_sel),
    .o_st_val_sel(o_st_val_sel), .o_stall_cnt(o_stall_cnt)
  );

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .SEL_W(2), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .i_freeze(i_freeze), .i_flush(i_flush),
    .i_id_valid(i_id_valid), .i_id_src1(i_id_src1), .i_id_src2(i_id_src2),
    .i_id_src2_is_reg(i_id_src2_is_reg), .i_id_is_store(i_id_is_store),
    .i_id_dest(i_id_dest), .i_id_wb_en(i_id_wb_en), .i_id_mem_read(i_id_mem_read),
    .o_hazard_stall(b_hazard_stall), .o_val1_sel(b_val1_sel), .o_val2_sel(b_val2_sel),
    .o_st_val_sel(b_st_val_sel), .o_stall_cnt(b_stall_cnt)
  );

  // One ID instruction plus its expected behaviour in each build.
  typedef struct {
    int v, s1, s2, s2r, st, d, wb, mr, fl;
    int stall_f, sel1_f, sel2_f, selst_f;
    int stall_n;
  } vec_t;

  typedef struct {
    int sel1, sel2, selst, cnt;
  } exp_t;

  vec_t tbl[16];
  exp_t sb[$];

  int total;
  int bad;
  int exp_cnt;
  int last_sel1, last_sel2, last_selst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic drive(input vec_t t, input int frz);
    i_freeze         = (frz != 0);
    i_flush          = (t.fl != 0);
    i_id_valid       = (t.v != 0);
    i_id_src1        = 5'(t.s1);
    i_id_src2        = 5'(t.s2);
    i_id_src2_is_reg = (t.s2r != 0);
    i_id_is_store    = (t.st != 0);
    i_id_dest        = 5'(t.d);
    i_id_wb_en       = (t.wb != 0);
    i_id_mem_read    = (t.mr != 0);
  endtask

  task automatic drive_idle();
    vec_t t;
    t = '{default: 0};
    drive(t, 0);
  endtask

  function automatic int sat7(input int c);
    return (c > 7) ? 7 : c;
  endfunction

  // Present one instruction, count its stall cycles, then check its selects.
  task automatic run_row(input int idx);
    vec_t t;
    exp_t e;
    int   n;
    int   exp_stall;
    t = tbl[idx];
    @(negedge clk);
    drive(t, 0);
`ifdef FWD_HAZARD_FORWARDING_EN
    exp_stall = t.stall_f;
    e.sel1    = t.sel1_f;
    e.sel2    = t.sel2_f;
    e.selst   = t.selst_f;
`else
    exp_stall = t.stall_n;
    e.sel1    = 0;
    e.sel2    = 0;
    e.selst   = 0;
`endif
    exp_cnt = exp_cnt + exp_stall;
    e.cnt   = exp_cnt;
    sb.push_back(e);
    #1;
    n = 0;
    while (o_hazard_stall && n < 10) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk($sformatf("row%0d_stall_cycles", idx), n, exp_stall);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("row%0d_val1_sel", idx), int'(o_val1_sel), e.sel1);
    chk($sformatf("row%0d_val2_sel", idx), int'(o_val2_sel), e.sel2);
    chk($sformatf("row%0d_st_val_sel", idx), int'(o_st_val_sel), e.selst);
    chk($sformatf("row%0d_stall_cnt", idx), int'(o_stall_cnt), e.cnt);
    chk($sformatf("row%0d_stall_cnt_sat", idx), int'(b_stall_cnt), sat7(e.cnt));
    last_sel1  = e.sel1;
    last_sel2  = e.sel2;
    last_selst = e.selst;
  endtask

  initial begin
    total = 0; bad = 0; exp_cnt = 0;
    last_sel1 = 0; last_sel2 = 0; last_selst = 0;

    //           v  s1 s2 s2r st  d wb mr fl  stF s1F s2F stF  stallN
    tbl[0]  = '{1,  1, 2, 1, 0,  3, 1, 0, 0,  0,  0,  0,  0,  0}; // ADD r3
    tbl[1]  = '{1,  3, 6, 1, 0,  4, 1, 0, 0,  0,  1,  0,  0,  2}; // SUB uses r3
    tbl[2]  = '{1,  1, 2, 1, 0,  5, 1, 0, 0,  0,  0,  0,  0,  0}; // ADD r5
    tbl[3]  = '{1,  9, 0, 0, 0,  8, 1, 0, 0,  0,  0,  0,  0,  0}; // independent
    tbl[4]  = '{1, 10, 5, 0, 1,  0, 0, 0, 0,  0,  0,  0,  2,  1}; // SW data r5
    tbl[5]  = '{1,  1, 0, 0, 0,  7, 1, 1, 0,  0,  0,  0,  0,  0}; // LW r7
    tbl[6]  = '{1,  2, 7, 1, 0,  9, 1, 0, 0,  1,  0,  2,  0,  2}; // ADD uses r7
    tbl[7]  = '{1,  1, 2, 1, 0,  0, 1, 0, 0,  0,  0,  0,  0,  0}; // write r0
    tbl[8]  = '{1,  0, 9, 0, 0, 12, 1, 0, 0,  0,  0,  0,  0,  0}; // r0 + imm
    tbl[9]  = '{1,  1, 0, 0, 0,  7, 1, 1, 0,  0,  0,  0,  0,  0}; // LW r7
    tbl[10] = '{1,  2, 7, 1, 0,  9, 1, 0, 1,  0,  0,  0,  0,  0}; // flushed use
    tbl[11] = '{0,  0, 0, 0, 0,  0, 0, 0, 0,  0,  0,  0,  0,  0}; // idle
    tbl[12] = '{0,  0, 0, 0, 0,  0, 0, 0, 0,  0,  0,  0,  0,  0}; // idle
    tbl[13] = '{1,  1, 2, 1, 0, 12, 1, 0, 0,  0,  0,  0,  0,  0}; // ADD r12
    tbl[14] = '{1, 12, 0, 0, 0,  7, 1, 1, 0,  0,  1,  0,  0,  2}; // LW r7 [r12]
    tbl[15] = '{1,  2, 7, 1, 0,  9, 1, 0, 0,  1,  0,  2,  0,  2}; // ADD uses r7

    // Reset state, with ID presenting a would-be consumer.
    rst_n = 1'b0;
    drive(tbl[15], 0);
    #12;
    chk("reset_hazard", int'(o_hazard_stall), 0);
    chk("reset_val1_sel", int'(o_val1_sel), 0);
    chk("reset_val2_sel", int'(o_val2_sel), 0);
    chk("reset_st_val_sel", int'(o_st_val_sel), 0);
    chk("reset_stall_cnt", int'(o_stall_cnt), 0);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) run_row(i);

    // Freeze for three edges while a load-use hazard is pending.
    @(negedge clk);
    drive(tbl[15], 1);
    #1;
    chk("freeze_hazard_pre", int'(o_hazard_stall), 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("freeze%0d_hazard", k), int'(o_hazard_stall), 1);
      chk($sformatf("freeze%0d_val1_sel", k), int'(o_val1_sel), last_sel1);
      chk($sformatf("freeze%0d_val2_sel", k), int'(o_val2_sel), last_sel2);
      chk($sformatf("freeze%0d_st_val_sel", k), int'(o_st_val_sel), last_selst);
      chk($sformatf("freeze%0d_stall_cnt", k), int'(o_stall_cnt), exp_cnt);
    end
    run_row(15);

    // Asynchronous reset in the middle of a stall.
    run_row(13);
    run_row(14);
    @(negedge clk);
    drive(tbl[15], 0);
    #1;
    chk("midrst_hazard_pre", int'(o_hazard_stall), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_hazard", int'(o_hazard_stall), 0);
    chk("midrst_val1_sel", int'(o_val1_sel), 0);
    chk("midrst_val2_sel", int'(o_val2_sel), 0);
    chk("midrst_st_val_sel", int'(o_st_val_sel), 0);
    chk("midrst_stall_cnt", int'(o_stall_cnt), 0);
    chk("midrst_stall_cnt_sat", int'(b_stall_cnt), 0);
    exp_cnt = 0;
    sb.delete();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;

    // Repeated load-use pairs drive the 3-bit counter into saturation.
    for (int k = 0; k < 9; k++) begin
      run_row(5);
      run_row(6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller for the execute stage.
- Keeps a shadow copy of register-usage info for the instructions in EX, MEM and WB, one slot per stage.
- Drives the three execute-stage forwarding mux selects as registered outputs: operand 1, operand 2 and store value.
- Detects load-use hazards and requests a one-cycle ID stall with an EX bubble.
- Counts stall cycles for performance monitoring.

Parameters:
- REG_ADDR_W, 5, register-file address width; register 0 is hardwired zero.
- SEL_W, 2, forwarding-select width; equals shared FORW_SEL_LEN.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous reset, active-low.
- freeze  in  1  global pipeline hold (memory wait); all state holds.
- flush  in  1  taken branch; kill the ID instruction.
- id_valid  in  1  ID holds a real instruction.
- id_src1  in  REG_ADDR_W  operand-1 source register.
- id_src2  in  REG_ADDR_W  operand-2 source register.
- id_src2_is_reg  in  1  operand 2 comes from a register, not an immediate.
- id_is_store  in  1  instruction is a store; its store data is read from id_src2.
- id_dest  in  REG_ADDR_W  destination register.
- id_wb_en  in  1  instruction writes the register file.
- id_mem_read  in  1  instruction is a load.
- hazard_stall  out  1  combinational; hold PC and IF/ID, bubble EX.
- val1_sel  out  SEL_W  registered; operand-1 forwarding select.
- val2_sel  out  SEL_W  registered; operand-2 forwarding select.
- st_val_sel  out  SEL_W  registered; store-value forwarding select.
- stall_cnt  out  CNT_W  saturating count of hazard stall cycles.

Behaviour:
- Select encoding, defined in the shared package:
  - SEL_REG = 0: register-file value.
  - SEL_MEM = 1: MEM-stage ALU result.
  - SEL_WB = 2: WB-stage result.
  - Code 3 is never driven.
- Slot contents: EX, MEM and WB slots each hold {valid, dest, wb_en, mem_read}.
- A slot "writes r" when valid & wb_en & dest == r & r != 0.
- Reset (rst low, asynchronous):
  - all slots invalid;
  - val1_sel, val2_sel and st_val_sel = SEL_REG;
  - stall_cnt = 0;
  - hazard_stall = 0 whenever slots are invalid.
- Hazard detection (combinational):
  - hazard_stall = id_valid & !flush & EX slot valid & EX.mem_read & EX.wb_en & EX.dest != 0 & (EX.dest == id_src1 | (EX.dest == id_src2 & (id_src2_is_reg | id_is_store))).
- Rising edge, priority freeze > flush > hazard > normal:
  - freeze: all slots, selects and stall_cnt hold.
  - flush or hazard_stall or !id_valid:
    - WB <= MEM, MEM <= EX;
    - EX <= bubble (valid = 0);
    - selects <= SEL_REG.
  - normal:
    - WB <= MEM, MEM <= EX, EX <= {1, id_dest, id_wb_en, id_mem_read}.
    - Each select is computed from its ID source against the pre-edge slots: EX slot writes src -> SEL_MEM; else MEM slot writes src -> SEL_WB; else SEL_REG.
    - EX takes priority over MEM (youngest producer wins).
- Select gating:
  - val2_sel is forced to SEL_REG when !id_src2_is_reg.
  - st_val_sel is SEL_REG unless id_is_store.
- Latency: selects are valid in the same cycle the instruction occupies EX.
- Load-use: exactly one stall cycle; the next cycle the load is in MEM and the consumer enters EX with SEL_WB.
- stall_cnt: increments on each non-frozen edge where hazard_stall = 1; saturates at all-ones with no wrap.
- Simultaneous flush and hazard: flush wins; no stall is counted.
- Reset mid-stall: hazard_stall drops immediately because the slots are cleared.

Optional Feature:
- Macro: FWD_HAZARD_FORWARDING_EN.
- Defined: behaviour as above.
- Undefined:
  - All selects are held at SEL_REG.
  - hazard_stall asserts on any RAW against a writing EX or MEM slot, load or not, under the same source and flush qualifiers as above.
  - A dependent instruction therefore stalls until its producer reaches WB; the register file is assumed write-first.
  - stall_cnt counts these stalls.

Decomposition:
- Shared package / defines:
  - FORW_SEL_LEN;
  - SEL_REG / SEL_MEM / SEL_WB constants;
  - REG_FILE_ADDR_LEN;
  - slot record typedef {valid, dest, wb_en, mem_read}.
- One natural sub-module, fwd_match: compares one source against the EX and MEM slots and returns a select plus a RAW flag. It is instantiated three times (src1, src2, store).

Test Plan:
- ADD r3 <- ...; SUB uses r3 as src1 the next cycle -> val1_sel = 1 in SUB's EX cycle; hazard_stall never asserts.
- Producer of r5, one independent instruction, then a store with data r5 -> st_val_sel = 2; val1_sel = val2_sel = 0.
- LW r7; then ADD uses r7 as src2 -> hazard_stall = 1 for one cycle; EX bubble; then val2_sel = 2; stall_cnt = 1.
- Writes to r0 and an immediate-operand consumer -> all selects 0, no stall; the same LW with flush = 1 -> no stall, stall_cnt unchanged.
- freeze held 3 cycles during a pending load-use -> slots, selects and stall_cnt unchanged; resumes identically after release.
- Assert rst low mid-stall -> hazard_stall = 0 and selects = 0 immediately (asynchronously); stall_cnt = 0; preload the counter to 0xFFFF and stall -> holds 0xFFFF.
